// File: rtl/tdm_demux8.sv
// Receive-side 8-channel TDM demultiplexer: steers serial samples into a shadow bank via a
// one-hot slot decoder and publishes each complete frame with a one-cycle valid pulse.
module tdm_demux8 #(
  parameter int unsigned W = 1
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [W-1:0]   f,
  input  logic           sync,
  input  logic           En,
  output logic [8*W-1:0] w,
  output logic [2:0]     s,
  output logic           valid,
  output logic           err,
  output logic           locked
);

  typedef enum logic [0:0] {StHunt, StRun} state_e;

  state_e         state_q, state_d;
  logic [8*W-1:0] shadow_q;
  logic [8*W-1:0] w_q, w_d;
  logic [2:0]     s_q, s_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           locked_q;

  logic           wr_en;
  logic [2:0]     wr_slot;
  logic [7:0]     slot_sel;

  // Next-state: decides which shadow slot (if any) is written and whether a frame completes.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    w_d     = w_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_slot = s_q;
    if (En) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            wr_en   = 1'b1;
            wr_slot = 3'd0;
            s_d     = 3'd1;
            state_d = StRun;
          end
        end
        StRun: begin
          if (s_q == 3'd0) begin
            if (sync) begin
              wr_en   = 1'b1;
              wr_slot = 3'd0;
              s_d     = 3'd1;
            end else begin
              err_d   = 1'b1;
              state_d = StHunt;
            end
          end else if (sync) begin
            // Early marker: abandon the partial frame and restart at slot 0.
            err_d   = 1'b1;
            wr_en   = 1'b1;
            wr_slot = 3'd0;
            s_d     = 3'd1;
          end else if (s_q == 3'd7) begin
            w_d     = {f, shadow_q[7*W-1:0]};
            valid_d = 1'b1;
            s_d     = 3'd0;
          end else begin
            wr_en   = 1'b1;
            s_d     = s_q + 3'd1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    slot_sel = 8'd0;
    if (wr_en) slot_sel = 8'd1 << wr_slot;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StHunt;
      shadow_q <= '0;
      w_q      <= '0;
      s_q      <= 3'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      s_q      <= s_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= (state_d == StRun);
      for (int k = 0; k < 8; k++) begin
        if (slot_sel[k]) shadow_q[k*W +: W] <= f;
      end
    end
  end

  assign w      = w_q;
  assign s      = s_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8 (W=1): frame-queue reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tdm_demux8;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       f, sync, En;
  logic [7:0] w;
  logic [2:0] s;
  logic       valid, err, locked;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  tdm_demux8 #(.W(1)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .f     (f),
    .sync  (sync),
    .En    (En),
    .w     (w),
    .s     (s),
    .valid (valid),
    .err   (err),
    .locked(locked)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of samples collected since the last marker.
  logic [7:0] m_w = 8'd0;
  logic [2:0] m_s = 3'd0;
  logic       m_valid = 1'b0, m_err = 1'b0, m_locked = 1'b0;
  logic       m_q[$];

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_w = 8'd0; m_s = 3'd0; m_valid = 1'b0; m_err = 1'b0; m_locked = 1'b0;
      m_q.delete();
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (En) begin
        if (sync) begin
          if (m_locked && m_q.size() != 0) m_err = 1'b1;
          m_q.delete();
          m_q.push_back(f);
          m_locked = 1'b1;
        end else if (m_locked) begin
          if (m_q.size() == 0) begin
            m_err = 1'b1;
            m_locked = 1'b0;
          end else begin
            m_q.push_back(f);
            if (m_q.size() == 8) begin
              for (int k = 0; k < 8; k++) m_w[k] = m_q[k];
              m_valid = 1'b1;
              m_q.delete();
            end
          end
        end
      end
      m_s = 3'(m_q.size());
    end
  end

  always @(negedge Clock) begin
    chk("cmp_w", 32'(w), 32'(m_w));
    chk("cmp_s", 32'(s), 32'(m_s));
    chk("cmp_valid", 32'(valid), 32'(m_valid));
    chk("cmp_err", 32'(err), 32'(m_err));
    chk("cmp_locked", 32'(locked), 32'(m_locked));
    chk("cmp_exclusive", 32'(valid & err), 32'd0);
  end

  task automatic step(input logic fv, input logic sv, input logic ev);
    f = fv; sync = sv; En = ev;
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic send_slots(input logic [7:0] data, input int first, input int last,
                            input bit gaps);
    for (int k = first; k <= last; k++) begin
      step(data[k], k == 0, 1'b1);
      if (gaps && k != last) begin
        step(1'b1, 1'b1, 1'b0);
        chk("gap_s_hold", 32'(s), 32'((k + 1) % 8));
      end
    end
  endtask

  int t_a, t_b;
  logic [7:0] w_before;

  initial begin
    Resetn = 1'b0; f = 1'b0; sync = 1'b0; En = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_w", 32'(w), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_valid_err", 32'({valid, err}), 32'd0);
    Resetn = 1'b1;

    // Hunt ignores unmarked samples.
    step(1'b1, 1'b0, 1'b1);
    chk("hunt_s", 32'(s), 32'd0);
    chk("hunt_locked", 32'(locked), 32'd0);

    // Pattern 1,0,1,1,0,0,1,0 in slots 0..7.
    send_slots(8'h4D, 0, 7, 1'b0);
    chk("t1_w", 32'(w), 32'h4D);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_s", 32'(s), 32'd0);
    chk("t1_locked", 32'(locked), 32'd1);

    // Back-to-back frames.
    send_slots(8'hA5, 0, 7, 1'b0);
    chk("t2_w_a5", 32'(w), 32'hA5);
    chk("t2_valid_a5", 32'(valid), 32'd1);
    t_a = cyc;
    send_slots(8'h3C, 0, 7, 1'b0);
    chk("t2_w_3c", 32'(w), 32'h3C);
    chk("t2_valid_3c", 32'(valid), 32'd1);
    t_b = cyc;
    chk("t2_spacing", 32'(t_b - t_a), 32'd8);

    // Gapped frame.
    send_slots(8'h4D, 0, 7, 1'b1);
    chk("t3_w", 32'(w), 32'h4D);
    chk("t3_valid", 32'(valid), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_valid_one_clk", 32'(valid), 32'd0);

    // Early marker at slot 4; that sample starts frame 0Fh.
    w_before = w;
    send_slots(8'hFF, 0, 3, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_no_valid", 32'(valid), 32'd0);
    chk("t4_w_kept", 32'(w), 32'(w_before));
    chk("t4_s", 32'(s), 32'd1);
    send_slots(8'h0F, 1, 7, 1'b0);
    chk("t4_w_0f", 32'(w), 32'h0F);
    chk("t4_valid_0f", 32'(valid), 32'd1);

    // Missing marker at slot 0.
    step(1'b1, 1'b0, 1'b1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_locked", 32'(locked), 32'd0);
    chk("t5_s", 32'(s), 32'd0);
    for (int i = 0; i < 4; i++) step(1'(i), 1'b0, 1'b1);
    chk("t5_ignored_s", 32'(s), 32'd0);
    chk("t5_still_hunt", 32'(locked), 32'd0);
    send_slots(8'h66, 0, 7, 1'b0);
    chk("t5_relock_w", 32'(w), 32'h66);

    // Asynchronous reset mid-frame at slot 5.
    send_slots(8'hFF, 0, 4, 1'b0);
    f = 1'b1; sync = 1'b0; En = 1'b1;
    #2;
    Resetn = 1'b0;
    #1;
    chk("t6_async_w", 32'(w), 32'd0);
    chk("t6_async_s", 32'(s), 32'd0);
    chk("t6_async_flags", 32'({valid, err, locked}), 32'd0);
    @(posedge Clock);
    #3;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    send_slots(8'h81, 0, 7, 1'b0);
    chk("t6_w_81", 32'(w), 32'h81);
    chk("t6_valid_81", 32'(valid), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Receive-side 8-channel time-division demultiplexer, the far end of the 8-to-1 multiplexer link. A sample stream arrives one channel per enabled cycle with a frame marker on channel 0. An internal one-hot slot decoder steers each sample into a shadow register. Each completed frame is transferred to the parallel output bank with a one-cycle valid pulse. Framing loss is detected, flagged and recovered automatically.

## Interface
- W, default 1: width of one channel sample.
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous active-low reset.
- f  input  W  serial sample stream; sample for slot s is presented on cycles with En=1.
- sync  input  1  frame marker; high with the slot-0 sample; sampled only when En=1.
- En  input  1  sample strobe; when 0, all state holds and no outputs change.
- w  output  8*W  demultiplexed frame; channel k occupies w[k*W +: W].
- s  output  3  slot index of the next expected sample.
- valid  output  1  one-cycle pulse: w has just been updated with a complete frame.
- err  output  1  one-cycle pulse: framing error detected.
- locked  output  1  high in RUN state.

## Operation
- Reset values: w=0, s=0, valid=0, err=0, locked=0, shadow=0, state=HUNT.
- Slot decode: the 3-bit s drives a 3-to-8 decoder. Enable is En, plus the state/sync qualification described below. The one-hot output selects the shadow register slice written on the clock edge.
- HUNT:
  - En=1 and sync=0: discard f; s stays 0; no error.
  - En=1 and sync=1: write f to shadow[0]; s becomes 1; go to RUN.
- RUN, En=1, slot 0 with sync=1: write shadow[0]; s becomes 1.
- RUN, En=1, slot 0 with sync=0: err pulse; discard f; go to HUNT; s stays 0.
- RUN, En=1, slots 1..6 with sync=0: write shadow[s]; s increments.
- RUN, En=1, slot 7 with sync=0:
  - w takes shadow[0..6] plus f in channel 7, in one edge.
  - valid pulses; s wraps to 0; stay in RUN.
- RUN, En=1, sync=1 at any slot 1..7 (early marker): err pulse; the partial frame is discarded (w and valid unaffected). This sample is treated as slot 0: write shadow[0], s becomes 1, stay in RUN.
- Shadow contents from a discarded frame are never forwarded. Any slot not rewritten before the next transfer is a don't-care and is not checked.
- s arithmetic is modulo 8. valid and err are never both high in the same cycle.
- Resetn low at any time, including mid-frame: all state returns immediately to reset values. The partial frame is lost. Operation resumes in HUNT on the first edge after release.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Latency: w and valid update on the same rising edge that samples slot 7. valid is high for exactly that following cycle.
- Back-to-back frames: valid pulses every 8 enabled cycles. With En held high, w sustains one frame per 8 clocks with zero bubble.
- En=0 cycles may be inserted anywhere; they stretch the frame but do not alter results. valid and err still last exactly one clock.
- err is asserted in the cycle after the offending sample edge. locked falls on the same edge for the slot-0-missing case.

## Test plan
- Reset, then with En=1 and W=1 send sync=1 and the serial pattern 1,0,1,1,0,0,1,0 for slots 0..7. Required: w=8'b01001101 with valid=1 one cycle after slot 7; s=0; locked=1.
- Send two consecutive frames, A5h then 3Ch in channel order, with En=1 continuously. Required: valid pulses exactly 8 clocks apart; w=A5h then w=3Ch; err never high.
- Send the same frame as the first test with En=0 inserted on every other cycle. Required: identical w, with valid one cycle after the slot-7 enabled edge; s holds during gaps.
- Once locked, assert sync=1 at slot 4 of a frame. Required: err pulse; previous w unchanged; no valid; s=1 on the next cycle. A following complete frame 0Fh yields w=0Fh.
- Once locked, present sync=0 at slot 0. Required: err pulse; locked=0; s=0; samples without sync are ignored until the next sync.
- Drop Resetn mid-frame at slot 5. Required: w, s, valid, err and locked all go to 0 immediately without waiting for a clock edge. After release, a full frame of 81h yields w=81h.
